// File: rtl/edc_encoder.sv
// Write-path check-bit generator for the 32-bit SEC memory EDC scheme.
// Encodes each accepted word, applies a one-shot injection mask, and holds results in a 2-entry skid FIFO.
module edc_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_data,
  output logic [7:0]       o_check,
  input  logic             i_inj_arm,
  input  logic [39:0]      i_inj_mask,
  output logic             o_inj_pending,
  output logic [CNT_W-1:0] o_word_cnt
);

  typedef struct packed {
    logic [7:0]  check;
    logic [31:0] data;
  } word_t;

  // Every data bit has a distinct weight-3 column, so the read-side syndrome
  // identifies any single flipped bit; each check bit covers 12 data bits.
  function automatic logic [7:0] calc_check(input logic [31:0] d);
    logic [7:0] c;
    c[0] = ^{d[0],  d[4],  d[8],  d[12], d[23:16]};
    c[1] = ^{d[1],  d[5],  d[9],  d[13], d[31:24]};
    c[2] = ^{d[2],  d[6],  d[10], d[14], d[19:16], d[27:24]};
    c[3] = ^{d[3],  d[7],  d[11], d[15], d[23:20], d[31:28]};
    c[4] = ^{d[16], d[20], d[24], d[28], d[7:0]};
    c[5] = ^{d[17], d[21], d[25], d[29], d[15:8]};
    c[6] = ^{d[18], d[22], d[26], d[30], d[3:0],   d[11:8]};
    c[7] = ^{d[19], d[23], d[27], d[31], d[7:4],   d[15:12]};
    return c;
  endfunction

  logic [1:0]  count_q;
  word_t       head_q;
  word_t       tail_q;
  logic [39:0] mask_q;
  logic        pending_q;
  logic [CNT_W-1:0] cnt_q;

  logic  accept;
  logic  pop;
  word_t enc_word;

  // Ready is a function of the registered fill level only, forced low while reset is held.
  assign o_ready  = ~i_rst & (count_q != 2'd2);
  assign o_valid  = (count_q != 2'd0);
  assign accept   = i_valid & o_ready;
  assign pop      = o_valid & i_ready;
  assign enc_word = word_t'({calc_check(i_data), i_data} ^ (pending_q ? mask_q : 40'h0));

  assign o_data        = head_q.data;
  assign o_check       = head_q.check;
  assign o_inj_pending = pending_q;
  assign o_word_cnt    = cnt_q;

  // NOTE: head/tail are only two words, so they are reset to give a defined o_data/o_check of 0 out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      unique case ({accept, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= enc_word;
          else                 tail_q <= enc_word;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Only reachable at count 1: the new word replaces the departing head.
          head_q <= enc_word;
        end
        default: ;
      endcase
    end
  end

  // An arm in the same cycle as an accept lets the accept see the old mask state first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mask_q    <= 40'h0;
      pending_q <= 1'b0;
    end else if (i_inj_arm) begin
      mask_q    <= i_inj_mask;
      pending_q <= 1'b1;
    end else if (accept) begin
      pending_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + 1'b1;
  end

  a_hold_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_valid && !i_ready) |=> (o_valid && $stable(o_data) && $stable(o_check)));

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    count_q != 2'd3);

endmodule

// File: tb/tb_edc_encoder.sv
// Self-checking bench for edc_encoder: directed scenarios plus randomized traffic
// compared against a queue-based model and a syndrome-decoding corrector model.
module tb_edc_encoder;
  localparam int CNT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic [31:0]      i_data;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_data;
  logic [7:0]       o_check;
  logic             i_inj_arm;
  logic [39:0]      i_inj_mask;
  logic             o_inj_pending;
  logic [CNT_W-1:0] o_word_cnt;

  edc_encoder #(.CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_check(o_check),
    .i_inj_arm(i_inj_arm), .i_inj_mask(i_inj_mask), .o_inj_pending(o_inj_pending),
    .o_word_cnt(o_word_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Data bits covered by each check bit, written out from the coverage lists.
  localparam logic [31:0] COVER [8] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  logic [31:0] enc_vecs [4] = '{32'h00000001, 32'h00010000, 32'hFFFFFFFF, 32'h00000000};
  logic [7:0]  enc_chks [4] = '{8'h51, 8'h15, 8'h00, 8'h00};

  // Model state: queue of words in flight, pending mask and accept count.
  logic [39:0]      m_q [$];
  logic             m_pending;
  logic [39:0]      m_mask;
  logic [CNT_W-1:0] m_cnt;

  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) c[i] = ^(d & COVER[i]);
    return c;
  endfunction

  function automatic logic [39:0] ref_word(input logic [31:0] d, input logic [39:0] m);
    return {ref_check(d), d} ^ m;
  endfunction

  // Read-side corrector: syndrome decode to a data column, a check bit, or uncorrectable.
  function automatic void correct(input logic [31:0] d, input logic [7:0] c,
                                  output logic [31:0] dc, output logic ue);
    logic [7:0] syn;
    logic [7:0] col;
    syn = ref_check(d) ^ c;
    dc  = d;
    ue  = (syn != 8'h0) && ($countones(syn) != 1);
    for (int k = 0; k < 32; k++) begin
      for (int i = 0; i < 8; i++) col[i] = COVER[i][k];
      if (syn == col) begin
        dc[k] = ~dc[k];
        ue    = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_pending = 1'b0;
    m_mask    = 40'h0;
    m_cnt     = '0;
  endfunction

  // Advance one clock with the current inputs and move the model along.
  task automatic tick();
    logic        acc;
    logic        pp;
    logic [39:0] w;
    acc = i_valid && (m_q.size() < 2);
    pp  = i_ready && (m_q.size() > 0);
    w   = ref_word(i_data, m_pending ? m_mask : 40'h0);
    @(posedge i_clk);
    #1;
    if (pp) m_q.delete(0);
    if (acc) begin
      m_q.push_back(w);
      m_cnt++;
    end
    if (i_inj_arm) begin
      m_mask    = i_inj_mask;
      m_pending = 1'b1;
    end else if (acc) begin
      m_pending = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    i_inj_arm = 1'b0; i_inj_mask = '0;
    repeat (2) @(posedge i_clk);
    #1;
    n_vec++;
    if ({o_valid, o_ready, o_inj_pending, o_data, o_check, o_word_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: valid=%b ready=%b pend=%b data=%h chk=%h cnt=%h, want all 0",
               o_valid, o_ready, o_inj_pending, o_data, o_check, o_word_cnt);
    end
    i_rst = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: ready=%b valid=%b, want ready=1 valid=0", o_ready, o_valid);
    end
  endtask

  task automatic test_encode();
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1;
      i_data  = enc_vecs[i];
      tick();
      n_vec++;
      if (o_valid !== 1'b1 || o_check !== enc_chks[i] || o_data !== enc_vecs[i]) begin
        n_err++;
        $display("FAIL encode[%0d]: valid=%b data=%h chk=%h, want valid=1 data=%h chk=%h",
                 i, o_valid, o_data, o_check, enc_vecs[i], enc_chks[i]);
      end
    end
    i_valid = 1'b0;
    tick();
    n_vec++;
    if (o_word_cnt !== CNT_W'(4) || o_valid !== 1'b0) begin
      n_err++;
      $display("FAIL encode_cnt: cnt=%0d valid=%b, want cnt=4 valid=0", o_word_cnt, o_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0]      w [3];
    logic [CNT_W-1:0] c0;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    c0 = m_cnt;
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data = w[i];
      tick();
      n_vec++;
      if (o_ready !== (i == 0) || o_valid !== 1'b1 || {o_check, o_data} !== ref_word(w[0], 40'h0)) begin
        n_err++;
        $display("FAIL bp_fill[%0d]: ready=%b valid=%b head=%h, want ready=%b valid=1 head=%h",
                 i, o_ready, o_valid, {o_check, o_data}, (i == 0), ref_word(w[0], 40'h0));
      end
    end
    n_vec++;
    if (o_word_cnt !== c0 + CNT_W'(2)) begin
      n_err++;
      $display("FAIL bp_cnt: cnt=%0d, want %0d", o_word_cnt, c0 + CNT_W'(2));
    end
    // Pop at count 2 while w[2] is still offered: ready is low, so only the pop happens.
    i_ready = 1'b1;
    tick();
    n_vec++;
    if ({o_check, o_data} !== ref_word(w[1], 40'h0) || o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_pop2: head=%h ready=%b, want head=%h ready=1",
               {o_check, o_data}, o_ready, ref_word(w[1], 40'h0));
    end
    // Push and pop together at count 1.
    tick();
    n_vec++;
    if ({o_check, o_data} !== ref_word(w[2], 40'h0) || o_valid !== 1'b1 || o_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_pushpop: head=%h valid=%b ready=%b, want head=%h valid=1 ready=1",
               {o_check, o_data}, o_valid, o_ready, ref_word(w[2], 40'h0));
    end
    i_valid = 1'b0;
    tick();
    n_vec++;
    if (o_valid !== 1'b0 || o_word_cnt !== c0 + CNT_W'(3)) begin
      n_err++;
      $display("FAIL bp_drain: valid=%b cnt=%0d, want valid=0 cnt=%0d",
               o_valid, o_word_cnt, c0 + CNT_W'(3));
    end
  endtask

  task automatic test_injection();
    logic [31:0] d;
    i_ready = 1'b1;
    i_valid = 1'b0;
    i_inj_arm = 1'b1; i_inj_mask = 40'h0000000001;
    tick();
    i_inj_arm = 1'b0;
    n_vec++;
    if (o_inj_pending !== 1'b1) begin
      n_err++;
      $display("FAIL inj_arm: pending=%b, want 1", o_inj_pending);
    end
    i_valid = 1'b1; i_data = 32'h00000001;
    tick();
    n_vec++;
    if (o_data !== 32'h0 || o_check !== 8'h51 || o_inj_pending !== 1'b0) begin
      n_err++;
      $display("FAIL inj_apply: data=%h chk=%h pend=%b, want data=00000000 chk=51 pend=0",
               o_data, o_check, o_inj_pending);
    end
    tick();
    n_vec++;
    if (o_data !== 32'h1 || o_check !== 8'h51) begin
      n_err++;
      $display("FAIL inj_oneshot: data=%h chk=%h, want data=00000001 chk=51", o_data, o_check);
    end
    // Zero mask: pending is set and consumed without altering the word.
    i_valid = 1'b0;
    i_inj_arm = 1'b1; i_inj_mask = 40'h0;
    tick();
    i_inj_arm = 1'b0;
    d = $urandom;
    i_valid = 1'b1; i_data = d;
    tick();
    i_valid = 1'b0;
    n_vec++;
    if ({o_check, o_data} !== ref_word(d, 40'h0) || o_inj_pending !== 1'b0) begin
      n_err++;
      $display("FAIL inj_zero: word=%h pend=%b, want word=%h pend=0",
               {o_check, o_data}, o_inj_pending, ref_word(d, 40'h0));
    end
    tick();
  endtask

  task automatic test_arm_collision();
    logic [39:0] ma, mb, mc;
    logic [31:0] d [4];
    ma = {8'($urandom), 32'($urandom)};
    mb = {8'($urandom), 32'($urandom)} | 40'h1;
    mc = {8'($urandom), 32'($urandom)} | 40'h100000000;
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    i_ready = 1'b1; i_valid = 1'b0;
    i_inj_arm = 1'b1; i_inj_mask = ma;
    tick();
    i_inj_mask = mb;
    tick();
    i_inj_arm = 1'b0;
    i_valid = 1'b1; i_data = d[0];
    tick();
    n_vec++;
    if ({o_check, o_data} !== ref_word(d[0], mb)) begin
      n_err++;
      $display("FAIL arm_overwrite: word=%h, want %h", {o_check, o_data}, ref_word(d[0], mb));
    end
    i_data = d[1];
    tick();
    i_valid = 1'b0;
    n_vec++;
    if ({o_check, o_data} !== ref_word(d[1], 40'h0) || o_inj_pending !== 1'b0) begin
      n_err++;
      $display("FAIL arm_overwrite_once: word=%h pend=%b, want %h pend=0",
               {o_check, o_data}, o_inj_pending, ref_word(d[1], 40'h0));
    end
    tick();
    // Arm coincident with an accept while idle: this word clean, the next masked.
    i_inj_arm = 1'b1; i_inj_mask = mc;
    i_valid = 1'b1; i_data = d[2];
    tick();
    i_inj_arm = 1'b0;
    n_vec++;
    if ({o_check, o_data} !== ref_word(d[2], 40'h0) || o_inj_pending !== 1'b1) begin
      n_err++;
      $display("FAIL arm_coincident: word=%h pend=%b, want %h pend=1",
               {o_check, o_data}, o_inj_pending, ref_word(d[2], 40'h0));
    end
    i_data = d[3];
    tick();
    i_valid = 1'b0;
    n_vec++;
    if ({o_check, o_data} !== ref_word(d[3], mc) || o_inj_pending !== 1'b0) begin
      n_err++;
      $display("FAIL arm_coincident_next: word=%h pend=%b, want %h pend=0",
               {o_check, o_data}, o_inj_pending, ref_word(d[3], mc));
    end
    tick();
  endtask

  task automatic test_roundtrip();
    logic [31:0] d, dc;
    logic        ue;
    int          a, b;
    i_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      d = $urandom;
      i_valid = 1'b0;
      i_inj_arm = 1'b1; i_inj_mask = 40'h1 << k;
      tick();
      i_inj_arm = 1'b0;
      i_valid = 1'b1; i_data = d;
      tick();
      correct(o_data, o_check, dc, ue);
      n_vec++;
      if (o_data !== (d ^ (32'h1 << k)) || dc !== d || ue !== 1'b0) begin
        n_err++;
        $display("FAIL rt_single[%0d]: data=%h corrected=%h ue=%b, want data=%h corrected=%h ue=0",
                 k, o_data, dc, ue, d ^ (32'h1 << k), d);
      end
    end
    for (int n = 0; n < 16; n++) begin
      a = $urandom_range(39, 0);
      b = (a + $urandom_range(39, 1)) % 40;
      d = $urandom;
      i_valid = 1'b0;
      i_inj_arm = 1'b1; i_inj_mask = (40'h1 << a) | (40'h1 << b);
      tick();
      i_inj_arm = 1'b0;
      i_valid = 1'b1; i_data = d;
      tick();
      correct(o_data, o_check, dc, ue);
      n_vec++;
      if (ue !== 1'b1) begin
        n_err++;
        $display("FAIL rt_double[%0d,%0d]: ue=%b corrected=%h orig=%h, want ue=1", a, b, ue, dc, d);
      end
    end
    i_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      i_valid    = ($urandom % 4) != 0;
      i_ready    = ($urandom % 3) != 0;
      i_inj_arm  = ($urandom % 8) == 0;
      i_inj_mask = {8'($urandom), 32'($urandom)};
      i_data     = $urandom;
      tick();
      n_vec++;
      if ({o_valid, o_ready, o_inj_pending, o_word_cnt} !==
          {m_q.size() != 0, m_q.size() < 2, m_pending, m_cnt}) begin
        n_err++;
        $display("FAIL rand_ctl[%0d]: valid=%b ready=%b pend=%b cnt=%0d, want %b %b %b %0d",
                 n, o_valid, o_ready, o_inj_pending, o_word_cnt,
                 m_q.size() != 0, m_q.size() < 2, m_pending, m_cnt);
      end
      if (m_q.size() != 0) begin
        n_vec++;
        if ({o_check, o_data} !== m_q[0]) begin
          n_err++;
          $display("FAIL rand_head[%0d]: head=%h, want %h", n, {o_check, o_data}, m_q[0]);
        end
      end
    end
    i_inj_arm = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0; i_valid = 1'b1;
    repeat (2) begin
      i_data = $urandom;
      tick();
    end
    i_valid = 1'b0;
    i_inj_arm = 1'b1; i_inj_mask = 40'hFF_0000_0001;
    tick();
    i_inj_arm = 1'b0;
    n_vec++;
    if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_inj_pending !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pre: valid=%b ready=%b pend=%b, want 1 0 1", o_valid, o_ready, o_inj_pending);
    end
    #2 i_rst = 1'b1;
    #1;
    n_vec++;
    if (o_valid !== 1'b0 || o_inj_pending !== 1'b0 || o_word_cnt !== '0 || o_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_async: valid=%b pend=%b cnt=%0d ready=%b, want 0 0 0 0",
               o_valid, o_inj_pending, o_word_cnt, o_ready);
    end
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    model_reset();
    i_ready = 1'b1;
    tick();
    n_vec++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_inj_pending !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_after: valid=%b ready=%b pend=%b, want 0 1 0", o_valid, o_ready, o_inj_pending);
    end
  endtask

  task automatic test_wrap();
    i_ready = 1'b1; i_valid = 1'b1;
    for (int n = 0; n < 65535; n++) begin
      i_data = n;
      tick();
    end
    n_vec++;
    if (o_word_cnt !== {CNT_W{1'b1}}) begin
      n_err++;
      $display("FAIL wrap_max: cnt=%h, want %h", o_word_cnt, {CNT_W{1'b1}});
    end
    tick();
    i_valid = 1'b0;
    n_vec++;
    if (o_word_cnt !== '0) begin
      n_err++;
      $display("FAIL wrap_zero: cnt=%h, want 0", o_word_cnt);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_encode();
    test_backpressure();
    test_injection();
    test_arm_collision();
    test_roundtrip();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
